// File: rtl/shader_pkg.sv
// Shared definitions for the shader instruction path: upload sequencer states
// and the default instruction store geometry used by the store and fetch stage.
`timescale 1ns/1ps
package shader_pkg;

    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_INSTR_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } upload_state_t;

endpackage

// File: rtl/shader_upload_ctrl.sv
// Moves one shader program at a time from a host valid/ready stream into the
// instruction store write port, holding GPU fetch off and reporting an XOR checksum.
`timescale 1ns/1ps
module shader_upload_ctrl
    import shader_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int INSTR_DEPTH = DEF_INSTR_DEPTH,
    localparam int AW = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_base_addr,
    input  logic [AW:0]            i_length,
    input  logic                   i_abort,
    input  logic                   i_data_valid,
    input  logic [INSTR_WIDTH-1:0] i_data,
    output logic                   o_data_ready,
    output logic                   o_mem_we,
    output logic [AW-1:0]          o_mem_addr,
    output logic [INSTR_WIDTH-1:0] o_mem_wdata,
    output logic                   o_busy,
    output logic                   o_gpu_hold,
    output logic                   o_done,
    output logic                   o_error,
    output logic [INSTR_WIDTH-1:0] o_checksum
);

    upload_state_t state, state_next;

    logic [AW-1:0]          base_q;
    logic [AW:0]            len_q;
    logic [AW:0]            count_q;
    logic [INSTR_WIDTH-1:0] acc_q;

    logic [AW+1:0] end_addr;
    logic          cmd_legal;
    logic          cmd_accept;
    logic          cmd_reject;
    logic          beat;
    logic          last_beat;

    // One spare bit so that an oversized length can never wrap back into range.
    assign end_addr   = {2'b00, i_base_addr} + {1'b0, i_length};
    assign cmd_legal  = (i_length != '0) && (end_addr <= (AW+2)'(INSTR_DEPTH));
    assign cmd_accept = (state == IDLE) && i_start && cmd_legal;
    assign cmd_reject = (state == IDLE) && i_start && !cmd_legal;

    assign beat      = (state == LOAD) && i_data_valid && !i_abort;
    assign last_beat = beat && ((count_q + (AW+1)'(1)) == len_q);

    assign o_data_ready = (state == LOAD) && !i_abort;
    assign o_busy       = (state != IDLE);
    assign o_gpu_hold   = o_busy;
    assign o_done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The write port is registered so the DONE cycle still carries the final word,
    // which keeps fetch held until that write has landed in the store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_error     <= 1'b0;
            o_checksum  <= '0;
        end else begin
            o_mem_we <= beat;
            o_error  <= cmd_reject;
            if (cmd_accept) begin
                base_q  <= i_base_addr;
                len_q   <= i_length;
                count_q <= '0;
                acc_q   <= '0;
            end
            if (beat) begin
                o_mem_addr  <= base_q + count_q[AW-1:0];
                o_mem_wdata <= i_data;
                acc_q       <= acc_q ^ i_data;
                count_q     <= count_q + (AW+1)'(1);
            end
            if (last_beat) begin
                o_checksum <= acc_q ^ i_data;
            end
        end
    end

endmodule

// File: tb/tb_shader_upload_ctrl.sv
// Directed bench for shader_upload_ctrl: a transaction-level model predicts every
// output each cycle, and literal expectations pin key results of each scenario.
`timescale 1ns/1ps
module tb_shader_upload_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base_addr = '0;
    logic [8:0]  i_length = '0;
    logic        i_abort = 1'b0;
    logic        i_data_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_data_ready;
    logic        o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_gpu_hold;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_checksum;

    shader_upload_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_length     (i_length),
        .i_abort      (i_abort),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_busy       (o_busy),
        .o_gpu_hold   (o_gpu_hold),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_checksum   (o_checksum)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int write_count = 0;
    int done_count = 0;
    int error_count = 0;
    logic [31:0] store [256];

    // Transaction-level model: an upload is "remaining words to go from next address".
    bit          m_busy = 0;
    bit          m_loading = 0;
    int          m_remaining = 0;
    logic [7:0]  m_next = '0;
    logic [31:0] m_acc = '0;
    bit          m_we = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [31:0] m_cksum = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_loading <= 0; m_remaining <= 0; m_next <= '0; m_acc <= '0;
            m_we <= 0; m_addr <= '0; m_wdata <= '0; m_done <= 0; m_err <= 0; m_cksum <= '0;
        end else begin
            m_we   <= 0;
            m_done <= 0;
            m_err  <= 0;
            if (!m_busy) begin
                if (i_start) begin
                    if (i_length != 0 && (int'(i_base_addr) + int'(i_length)) <= 256) begin
                        m_busy      <= 1;
                        m_loading   <= 1;
                        m_next      <= i_base_addr;
                        m_remaining <= int'(i_length);
                        m_acc       <= '0;
                    end else begin
                        m_err <= 1;
                    end
                end
            end else if (m_loading) begin
                if (i_abort) begin
                    m_busy    <= 0;
                    m_loading <= 0;
                end else if (i_data_valid) begin
                    m_we        <= 1;
                    m_addr      <= m_next;
                    m_wdata     <= i_data;
                    m_acc       <= m_acc ^ i_data;
                    m_next      <= m_next + 8'd1;
                    m_remaining <= m_remaining - 1;
                    if (m_remaining == 1) begin
                        m_loading <= 0;
                        m_done    <= 1;
                        m_cksum   <= m_acc ^ i_data;
                    end
                end
            end else begin
                m_busy <= 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, then record what the store received.
    always @(negedge clk) begin
        check_output("busy",       32'(o_busy),       32'(m_busy));
        check_output("gpu_hold",   32'(o_gpu_hold),   32'(m_busy));
        check_output("data_ready", 32'(o_data_ready), 32'(m_loading && !i_abort));
        check_output("mem_we",     32'(o_mem_we),     32'(m_we));
        check_output("done",       32'(o_done),       32'(m_done));
        check_output("error",      32'(o_error),      32'(m_err));
        check_output("checksum",   o_checksum,        m_cksum);
        if (m_we) begin
            check_output("mem_addr",  32'(o_mem_addr), 32'(m_addr));
            check_output("mem_wdata", o_mem_wdata,     m_wdata);
        end
        if (o_mem_we) begin
            store[o_mem_addr] = o_mem_wdata;
            write_count++;
        end
        if (o_done)  done_count++;
        if (o_error) error_count++;
    end

    task automatic apply_stimulus(input bit start, input logic [7:0] base, input logic [8:0] len,
                                  input bit abort, input bit valid, input logic [31:0] data);
        i_start      = start;
        i_base_addr  = base;
        i_length     = len;
        i_abort      = abort;
        i_data_valid = valid;
        i_data       = data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(0, 8'h00, 9'd0, 0, 0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ready"},    32'(o_data_ready), 32'h0);
        check_output({tag, "_we"},       32'(o_mem_we),     32'h0);
        check_output({tag, "_addr"},     32'(o_mem_addr),   32'h0);
        check_output({tag, "_wdata"},    o_mem_wdata,       32'h0);
        check_output({tag, "_busy"},     32'(o_busy),       32'h0);
        check_output({tag, "_hold"},     32'(o_gpu_hold),   32'h0);
        check_output({tag, "_done"},     32'(o_done),       32'h0);
        check_output({tag, "_error"},    32'(o_error),      32'h0);
        check_output({tag, "_checksum"}, o_checksum,        32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish before 100000ns");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int w0, d0, e0;
        logic [31:0] full_ck;
        for (int a = 0; a < 256; a++) store[a] = '0;

        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Back-to-back upload of four words.
        w0 = write_count; d0 = done_count;
        apply_stimulus(1, 8'h10, 9'd4, 0, 0, 32'h0);
        check_output("start_busy",  32'(o_busy),       32'h1);
        check_output("start_ready", 32'(o_data_ready), 32'h1);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h11);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h22);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h44);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h88);
        check_output("b2b_done_pulse", 32'(o_done),     32'h1);
        check_output("b2b_checksum",   o_checksum,      32'hFF);
        check_output("b2b_last_addr",  32'(o_mem_addr), 32'h13);
        idle(1);
        check_output("b2b_hold_drop",  32'(o_gpu_hold), 32'h0);
        check_output("b2b_we_drop",    32'(o_mem_we),   32'h0);
        idle(1);
        check_output("b2b_writes", 32'(write_count - w0), 32'd4);
        check_output("b2b_dones",  32'(done_count - d0),  32'd1);
        check_output("b2b_mem10",  store[8'h10], 32'h11);
        check_output("b2b_mem13",  store[8'h13], 32'h88);

        // Upload that ends exactly at the top of the store.
        apply_stimulus(1, 8'hFC, 9'd4, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hF0 + 32'(k));
        idle(2);
        check_output("top_memFF",    store[8'hFF], 32'hF3);
        check_output("top_checksum", o_checksum,   32'h0);

        // Rejected commands: overrun, zero length, oversize length.
        w0 = write_count; e0 = error_count;
        apply_stimulus(1, 8'hFD, 9'd4, 0, 0, 32'h0);
        check_output("err_pulse", 32'(o_error),    32'h1);
        check_output("err_hold",  32'(o_gpu_hold), 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hBAD);
        apply_stimulus(1, 8'h20, 9'd0, 0, 0, 32'h0);
        idle(1);
        apply_stimulus(1, 8'h00, 9'd257, 0, 0, 32'h0);
        idle(2);
        check_output("err_count",  32'(error_count - e0), 32'd3);
        check_output("err_writes", 32'(write_count - w0), 32'd0);

        // Valid gaps: pattern 1,0,0,1,0,1.
        w0 = write_count; d0 = done_count;
        apply_stimulus(1, 8'h40, 9'd3, 0, 0, 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hA1);
        apply_stimulus(0, 8'h00, 9'd0, 0, 0, 32'hDEAD);
        apply_stimulus(0, 8'h00, 9'd0, 0, 0, 32'hDEAD);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hB2);
        apply_stimulus(0, 8'h00, 9'd0, 0, 0, 32'hDEAD);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hC3);
        idle(2);
        check_output("gap_writes",   32'(write_count - w0), 32'd3);
        check_output("gap_dones",    32'(done_count - d0),  32'd1);
        check_output("gap_mem41",    store[8'h41], 32'hB2);
        check_output("gap_mem42",    store[8'h42], 32'hC3);
        check_output("gap_checksum", o_checksum,   32'hD0);

        // Abort after two of five beats, then a fresh upload.
        w0 = write_count; d0 = done_count;
        apply_stimulus(1, 8'h80, 9'd5, 0, 0, 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h1);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h2);
        apply_stimulus(0, 8'h00, 9'd0, 1, 1, 32'h3);
        check_output("abort_idle", 32'(o_busy), 32'h0);
        idle(2);
        check_output("abort_writes",   32'(write_count - w0), 32'd2);
        check_output("abort_dones",    32'(done_count - d0),  32'd0);
        check_output("abort_checksum", o_checksum,   32'hD0);
        check_output("abort_mem82",    store[8'h82], 32'h0);
        apply_stimulus(1, 8'h90, 9'd1, 0, 0, 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h5A);
        idle(2);
        check_output("after_abort_checksum", o_checksum,   32'h5A);
        check_output("after_abort_mem90",    store[8'h90], 32'h5A);

        // i_start while busy (LOAD and DONE) is ignored.
        w0 = write_count;
        apply_stimulus(1, 8'hA0, 9'd3, 0, 0, 32'h0);
        apply_stimulus(1, 8'h00, 9'd1, 0, 1, 32'h7);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h8);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h9);
        apply_stimulus(1, 8'h00, 9'd1, 0, 0, 32'h0);
        idle(3);
        check_output("busy_start_writes", 32'(write_count - w0), 32'd3);
        check_output("busy_start_memA2",  store[8'hA2], 32'h9);
        check_output("busy_start_mem00",  store[8'h00], 32'h0);

        // Asynchronous reset in the middle of an upload.
        apply_stimulus(1, 8'hB0, 9'd4, 0, 0, 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h11);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h12);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        i_data_valid = 1'b0;
        @(posedge clk); #1;
        idle(1);
        apply_stimulus(1, 8'hC0, 9'd2, 0, 0, 32'h0);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'h3C);
        apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'hC3);
        idle(2);
        check_output("post_rst_checksum", o_checksum,   32'hFF);
        check_output("post_rst_memC1",    store[8'hC1], 32'hC3);

        // Full-store upload.
        w0 = write_count; d0 = done_count;
        full_ck = '0;
        apply_stimulus(1, 8'h00, 9'd256, 0, 0, 32'h0);
        for (int k = 0; k < 256; k++) begin
            full_ck = full_ck ^ (32'(k) * 32'h9E37 + 32'h1);
            apply_stimulus(0, 8'h00, 9'd0, 0, 1, 32'(k) * 32'h9E37 + 32'h1);
        end
        idle(3);
        check_output("full_writes",   32'(write_count - w0), 32'd256);
        check_output("full_dones",    32'(done_count - d0),  32'd1);
        check_output("full_mem00",    store[8'h00], 32'h1);
        check_output("full_memFF",    store[8'hFF], 32'd255 * 32'h9E37 + 32'h1);
        check_output("full_checksum", o_checksum,   full_ck);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
